serial_add_ctrl: RTL

- Sequencing controller that performs a WIDTH-bit addition by issuing WIDTH/2 consecutive operations to one external 2-bit full-adder slice. The slice has inputs A0, A1, B0, B1 and carry-in, and outputs sum0, sum1 and carry-out.
- Each cycle the controller drives one 2-bit digit, LSB digit first, and chains the carry through an internal register.
- It sits between a requester (start/done handshake) and the combinational slice.

---
 rtl/serial_add_ctrl_if.sv | 24 ++
 rtl/serial_add_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl_if.sv
// Requester-side handshake bundle for serial_add_ctrl: start/operands in,
// busy/done/result out. The master modport is the requester, slave the controller.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             i_start;
  logic [WIDTH-1:0] i_opA;
  logic [WIDTH-1:0] i_opB;
  logic             i_carry;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_sum;
  logic             o_carry;

  modport master (
    output i_start, i_opA, i_opB, i_carry,
    input  o_busy, o_done, o_sum, o_carry
  );

  modport slave (
    input  i_start, i_opA, i_opB, i_carry,
    output o_busy, o_done, o_sum, o_carry
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// WIDTH-bit adder sequencer driving an external 2-bit full-adder slice, one digit
// per cycle, LSB first. Define SERIAL_ADD_OVF_EN to add the o_overflow output.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  serial_add_ctrl_if.slave   req,
  output logic               o_bitA0,
  output logic               o_bitA1,
  output logic               o_bitB0,
  output logic               o_bitB1,
  output logic               o_slice_carry,
  input  logic               i_sum0,
  input  logic               i_sum1,
  input  logic               i_slice_carry
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic               o_overflow
`endif
);

  localparam int DIGITS = WIDTH / 2;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic [IDX_W:0]     bit_idx_s;
  logic               last_s;

  assign bit_idx_s = {idx_q, 1'b0};
  assign last_s    = (idx_q == IDX_W'(DIGITS - 1));

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req.i_start) begin
          state_d = ST_RUN;
          idx_d   = '0;
          carry_d = req.i_carry;
          opa_d   = req.i_opA;
          opb_d   = req.i_opB;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d[bit_idx_s +: 2] = {i_sum1, i_sum0};
        carry_d               = i_slice_carry;
        // The final digit also commits the carry-out and leaves RUN.
        if (last_s) begin
          cout_d  = i_slice_carry;
          idx_d   = '0;
          state_d = ST_DONE;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (i_sum1 != opa_q[WIDTH-1]);
`endif
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Slice drive, forced low outside RUN
  always_comb begin
    o_bitA0       = 1'b0;
    o_bitA1       = 1'b0;
    o_bitB0       = 1'b0;
    o_bitB1       = 1'b0;
    o_slice_carry = 1'b0;
    if (state_q == ST_RUN) begin
      {o_bitA1, o_bitA0} = opa_q[bit_idx_s +: 2];
      {o_bitB1, o_bitB0} = opb_q[bit_idx_s +: 2];
      o_slice_carry      = carry_q;
    end else begin
      o_bitA0       = 1'b0;
      o_bitA1       = 1'b0;
      o_bitB0       = 1'b0;
      o_bitB1       = 1'b0;
      o_slice_carry = 1'b0;
    end
  end

  assign req.o_busy  = (state_q == ST_RUN);
  assign req.o_done  = (state_q == ST_DONE);
  assign req.o_sum   = sum_q;
  assign req.o_carry = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign o_overflow  = ovf_q;
`endif

endmodule
